// File: rtl/alu_74ls381.sv
// alu_74ls381 -- registered 4-bit ALU with the 74LS381 function set.
// Two 4-bit operands and a 3-bit select produce a 4-bit result and a
// carry/borrow flag, both registered (one cycle of latency).
// Optional feature: define ALU381_CIN_EN to add the cin port. cin is the
// carry-in for add and the borrow-in for both subtracts. Without the macro
// the port does not exist and all arithmetic uses 0.
module alu_74ls381 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] s,
`ifdef ALU381_CIN_EN
  input  logic       cin,
`endif
  output logic [3:0] f,
  output logic       c
);

  // Function select encodings.
  localparam logic [2:0] OP_CLEAR  = 3'b000;
  localparam logic [2:0] OP_B_SUB_A = 3'b001;
  localparam logic [2:0] OP_A_SUB_B = 3'b010;
  localparam logic [2:0] OP_ADD    = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_AND    = 3'b110;
  localparam logic [2:0] OP_PRESET = 3'b111;

  // Carry/borrow-in, forced to 0 when the port is not built.
  logic       carry_in;
`ifdef ALU381_CIN_EN
  assign carry_in = cin;
`else
  assign carry_in = 1'b0;
`endif

  // Operands widened to 5 bits so bit 4 of the result is the carry, or the
  // borrow (bit 4 is set exactly when the true difference is negative).
  logic [4:0] a_ext;
  logic [4:0] b_ext;
  logic [4:0] cin_ext;
  logic [4:0] sum_ba;
  logic [4:0] sum_ab;
  logic [4:0] sum_add;

  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  assign cin_ext = {4'b0000, carry_in};
  assign sum_ba  = b_ext - a_ext - cin_ext;
  assign sum_ab  = a_ext - b_ext - cin_ext;
  assign sum_add = a_ext + b_ext + cin_ext;

  logic [3:0] f_q;
  logic [3:0] f_d;
  logic       c_q;
  logic       c_d;

  // Next-state selection of result and flag from the function select.
  always_comb begin
    f_d = 4'b0000;
    c_d = 1'b0;
    unique case (s)
      OP_CLEAR: begin
        f_d = 4'b0000;
        c_d = 1'b0;
      end
      OP_B_SUB_A: begin
        f_d = sum_ba[3:0];
        c_d = sum_ba[4];
      end
      OP_A_SUB_B: begin
        f_d = sum_ab[3:0];
        c_d = sum_ab[4];
      end
      OP_ADD: begin
        f_d = sum_add[3:0];
        c_d = sum_add[4];
      end
      OP_XOR: f_d = a ^ b;
      OP_OR:  f_d = a | b;
      OP_AND: f_d = a & b;
      OP_PRESET: f_d = 4'b1111;
      default: begin
        f_d = 4'b0000;
        c_d = 1'b0;
      end
    endcase
  end

  // Output register; an asynchronous reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= 4'b0000;
      c_q <= 1'b0;
    end else begin
      f_q <= f_d;
      c_q <= c_d;
    end
  end

  assign f = f_q;
  assign c = c_q;

endmodule

// File: tb/tb_alu_74ls381.sv
// Directed, table-driven bench for alu_74ls381. Builds the cin port and
// its vectors only when ALU381_CIN_EN is defined.
`timescale 1ns/1ps
module tb_alu_74ls381;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] s;
  logic       cin;
  logic [3:0] f;
  logic       c;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic       cin;
    logic [4:0] exp_cf;
  } vec_t;

  vec_t vecs[$];

  alu_74ls381 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .s    (s),
`ifdef ALU381_CIN_EN
    .cin  (cin),
`endif
    .f    (f),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] exp_cf);
    n_checks++;
    if ({c, f} !== exp_cf) begin
      n_fail++;
      $display("FAIL %s: got {c,f}=%b, expected %b", name, {c, f}, exp_cf);
    end else begin
      $display("ok   %s: {c,f}=%b", name, {c, f});
    end
  endtask

  task automatic add_vec(input logic [3:0] va, input logic [3:0] vb,
                         input logic [2:0] vs, input logic vcin,
                         input logic [4:0] vexp);
    vec_t v;
    v.a = va; v.b = vb; v.s = vs; v.cin = vcin; v.exp_cf = vexp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] prev_cf;
    n_checks = 0;
    n_fail   = 0;

    // Hand-computed vectors: {c,f} expected one edge after application.
    add_vec(4'b0011, 4'b1111, 3'b000, 1'b0, 5'b00000);
    add_vec(4'b0011, 4'b1111, 3'b001, 1'b0, 5'b01100);
    add_vec(4'b1111, 4'b0001, 3'b010, 1'b0, 5'b01110);
    add_vec(4'b1111, 4'b0001, 3'b011, 1'b0, 5'b10000);
    add_vec(4'b1010, 4'b1100, 3'b100, 1'b0, 5'b00110);
    add_vec(4'b1010, 4'b1100, 3'b101, 1'b0, 5'b01110);
    add_vec(4'b1010, 4'b1100, 3'b110, 1'b0, 5'b01000);
    add_vec(4'b1010, 4'b1100, 3'b111, 1'b0, 5'b01111);
    add_vec(4'b0001, 4'b0011, 3'b010, 1'b0, 5'b11110);
    add_vec(4'b0001, 4'b0011, 3'b001, 1'b0, 5'b00010);
    add_vec(4'b1001, 4'b1000, 3'b011, 1'b0, 5'b10001);
    add_vec(4'b0101, 4'b0101, 3'b001, 1'b0, 5'b00000);
    add_vec(4'b0000, 4'b1111, 3'b010, 1'b0, 5'b10001);
    add_vec(4'b0110, 4'b0011, 3'b011, 1'b0, 5'b01001);
    add_vec(4'b0000, 4'b0000, 3'b000, 1'b0, 5'b00000);
`ifdef ALU381_CIN_EN
    add_vec(4'b1111, 4'b0000, 3'b011, 1'b1, 5'b10000);
    add_vec(4'b0000, 4'b0000, 3'b010, 1'b1, 5'b11111);
    add_vec(4'b1010, 4'b1100, 3'b100, 1'b1, 5'b00110);
    add_vec(4'b0010, 4'b0101, 3'b001, 1'b1, 5'b00010);
    add_vec(4'b0000, 4'b0000, 3'b111, 1'b1, 5'b01111);
    add_vec(4'b0101, 4'b0010, 3'b000, 1'b1, 5'b00000);
`endif

    // Reset asserted from time zero: outputs clear with no clock edge.
    rst_n = 1'b0;
    a = 4'b0000; b = 4'b0000; s = 3'b111; cin = 1'b0;
    #1;
    check("reset_initial", 5'b00000);
    @(posedge clk); #1;
    check("reset_holds_over_edge", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table loop: drive on the falling edge, confirm the old value still
    // holds (one-cycle latency), then check the new value after the edge.
    prev_cf = 5'b00000;
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; s = vecs[i].s; cin = vecs[i].cin;
      #1;
      check($sformatf("hold_before_edge[%0d]", i), prev_cf);
      @(posedge clk); #1;
      check($sformatf("vec[%0d] s=%b a=%b b=%b cin=%b", i, vecs[i].s,
                      vecs[i].a, vecs[i].b, vecs[i].cin), vecs[i].exp_cf);
      prev_cf = vecs[i].exp_cf;
      @(negedge clk);
    end

    // Inputs changed between edges must not disturb the registered output.
    a = 4'b1111; b = 4'b0001; s = 3'b011; cin = 1'b0;
    @(posedge clk); #1;
    check("seq_add_carry", 5'b10000);
    #1;
    a = 4'b1010; b = 4'b1100; s = 3'b110;
    #2;
    check("seq_mid_cycle_change_ignored", 5'b10000);
    @(posedge clk); #1;
    check("seq_and_after_change", 5'b01000);

    // Reset asserted mid-cycle with non-zero outputs clears them at once.
    s = 3'b111;
    @(posedge clk); #1;
    check("seq_preset_before_reset", 5'b01111);
    #1;
    rst_n = 1'b0;
    #1;
    check("seq_async_reset_clears", 5'b00000);
    @(posedge clk); #1;
    check("seq_reset_holds", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'b0001; b = 4'b0010; s = 3'b011; cin = 1'b0;
    #1;
    check("seq_no_capture_before_edge", 5'b00000);
    @(posedge clk); #1;
    check("seq_first_capture_after_reset", 5'b00011);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
